// File: rtl/voxel_bin_accumulator.sv
// Voxel-grid event binner: pops DVS events, bins them into {time bin, gy, gx, pol}
// saturating counters in a dual-port RAM, advancing time bins from event timestamps.
module voxel_bin_accumulator #(
    parameter int unsigned GRID_BITS = 4,
    parameter int unsigned XY_SHIFT  = 5,
    parameter int unsigned TB_BITS   = 2,
    parameter int unsigned BIN_TICKS = 5000,
    parameter int unsigned CNT_BITS  = 8,
    localparam int unsigned ADDR_W   = TB_BITS + 2 * GRID_BITS + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [8:0]          ev_x,
    input  logic [8:0]          ev_y,
    input  logic                ev_pol,
    input  logic [15:0]         ev_ts,
    output logic                fifo_pop,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CNT_BITS-1:0] rd_data,
    output logic [TB_BITS-1:0]  cur_bin,
    output logic                bin_done,
    output logic [TB_BITS-1:0]  done_bin,
    output logic                ev_dropped,
    output logic                busy
);
    localparam int unsigned XY_W  = 9;
    localparam int unsigned TS_W  = 16;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned BIN_W = 2 * GRID_BITS + 1;
    localparam logic [XY_W-1:0]     GRID_LIM = XY_W'(1 << GRID_BITS);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [TS_W-1:0]     TICKS    = TS_W'(BIN_TICKS);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_CLEAR, S_RD, S_WR} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [XY_W-1:0]     gx_q, gx_d, gy_q, gy_d;
    logic                pol_q, pol_d;
    logic                first_seen_q, first_seen_d;
    logic [TS_W-1:0]     bin_start_q, bin_start_d;
    logic [TB_BITS-1:0]  cur_bin_q, cur_bin_d;
    logic                bin_done_q, bin_done_d;
    logic [TB_BITS-1:0]  done_bin_q, done_bin_d;
    logic                ev_dropped_q, ev_dropped_d;
    logic                busy_q, busy_d;
    logic [CNT_BITS-1:0] rd_data_q;
    logic [CNT_BITS-1:0] rmw_q;

    logic [CNT_BITS-1:0] mem [DEPTH];
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [CNT_BITS-1:0] mem_wdata_c;
    logic [ADDR_W-1:0]   ev_addr_c;
    logic [TS_W-1:0]     elapsed_c;

    assign ev_addr_c = {cur_bin_q, gy_q[GRID_BITS-1:0], gx_q[GRID_BITS-1:0], pol_q};
    assign elapsed_c = ev_ts - bin_start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            gx_q         <= '0;
            gy_q         <= '0;
            pol_q        <= 1'b0;
            first_seen_q <= 1'b0;
            bin_start_q  <= '0;
            cur_bin_q    <= '0;
            bin_done_q   <= 1'b0;
            done_bin_q   <= '0;
            ev_dropped_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            pol_q        <= pol_d;
            first_seen_q <= first_seen_d;
            bin_start_q  <= bin_start_d;
            cur_bin_q    <= cur_bin_d;
            bin_done_q   <= bin_done_d;
            done_bin_q   <= done_bin_d;
            ev_dropped_q <= ev_dropped_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gx_d         = gx_q;
        gy_d         = gy_q;
        pol_d        = pol_q;
        first_seen_d = first_seen_q;
        bin_start_d  = bin_start_q;
        cur_bin_d    = cur_bin_q;
        bin_done_d   = 1'b0;
        done_bin_d   = done_bin_q;
        ev_dropped_d = 1'b0;
        fifo_pop     = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = ev_addr_c;
        mem_wdata_c  = '0;
        unique case (state_q)
            S_INIT: begin
                mem_we_c   = 1'b1;
                mem_addr_c = cnt_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    gx_d     = ev_x >> XY_SHIFT;
                    gy_d     = ev_y >> XY_SHIFT;
                    pol_d    = ev_pol;
                    state_d  = S_RD;
                    if (!first_seen_q) begin
                        first_seen_d = 1'b1;
                        bin_start_d  = ev_ts;
                    end else if (elapsed_c >= TICKS) begin
                        // Long gaps resync to this event and advance a single bin.
                        bin_done_d  = 1'b1;
                        done_bin_d  = cur_bin_q;
                        cur_bin_d   = cur_bin_q + 1'b1;
                        bin_start_d = ev_ts;
                        cnt_d       = '0;
                        state_d     = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                mem_we_c   = 1'b1;
                mem_addr_c = {cur_bin_q, cnt_q[BIN_W-1:0]};
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q[BIN_W-1:0] == '1) state_d = S_RD;
            end
            S_RD: begin
                if (gx_q >= GRID_LIM || gy_q >= GRID_LIM) begin
                    ev_dropped_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                mem_we_c    = 1'b1;
                mem_wdata_c = (rmw_q == CNT_MAX) ? CNT_MAX : rmw_q + 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
        busy_d = (state_d == S_INIT) || (state_d == S_CLEAR);
    end

    // Port A: internal read-modify-write; read-first.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
        rmw_q <= mem[mem_addr_c];
    end

    // Port B: consumer read, old data on a same-cycle internal write.
    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= mem[rd_addr];
    end

    assign rd_data    = rd_data_q;
    assign cur_bin    = cur_bin_q;
    assign bin_done   = bin_done_q;
    assign done_bin   = done_bin_q;
    assign ev_dropped = ev_dropped_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_voxel_bin_accumulator.sv
// Bench for voxel_bin_accumulator: directed steps plus a random event burst,
// checked against an array-based voxel model.
module tb_voxel_bin_accumulator;
    localparam int NE = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty, ev_pol, fifo_pop, bin_done, ev_dropped, busy;
    logic [8:0]  ev_x, ev_y;
    logic [15:0] ev_ts;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic [1:0]  cur_bin, done_bin;

    logic        fifo_empty2, ev_pol2, fifo_pop2, bin_done2, ev_dropped2, busy2;
    logic [8:0]  ev_x2, ev_y2;
    logic [15:0] ev_ts2;
    logic [8:0]  rd_addr2;
    logic [7:0]  rd_data2;
    logic [1:0]  cur_bin2, done_bin2;

    always #5 clk = ~clk;

    voxel_bin_accumulator dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .ev_x(ev_x), .ev_y(ev_y),
        .ev_pol(ev_pol), .ev_ts(ev_ts), .fifo_pop(fifo_pop), .rd_addr(rd_addr),
        .rd_data(rd_data), .cur_bin(cur_bin), .bin_done(bin_done), .done_bin(done_bin),
        .ev_dropped(ev_dropped), .busy(busy)
    );

    voxel_bin_accumulator #(.GRID_BITS(3)) dut_g3 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty2), .ev_x(ev_x2), .ev_y(ev_y2),
        .ev_pol(ev_pol2), .ev_ts(ev_ts2), .fifo_pop(fifo_pop2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .cur_bin(cur_bin2), .bin_done(bin_done2), .done_bin(done_bin2),
        .ev_dropped(ev_dropped2), .busy(busy2)
    );

    typedef struct {int x; int y; int pol; int ts;} ev_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    ev_t  evq[$];
    int   exp_done_q[$];
    int   m_mem[NE];
    bit   m_first;
    int   m_bin, m_start;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic ev_t mk(input int x, input int y, input int pol, input int ts);
        ev_t e;
        e.x = x; e.y = y; e.pol = pol; e.ts = ts;
        return e;
    endfunction

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 0;
        m_first = 1'b0; m_bin = 0; m_start = 0;
        exp_done_q.delete();
    endtask

    // Voxel model: time-bin ring of 4 x 16 x 16 x 2 counters saturating at 255.
    task automatic model_apply(input ev_t e, output bit adv, output bit drop);
        int gx, gy, el, a;
        gx = e.x >> 5;
        gy = e.y >> 5;
        adv = 1'b0;
        if (!m_first) begin
            m_first = 1'b1;
            m_start = e.ts;
        end else begin
            el = (e.ts - m_start + 65536) % 65536;
            if (el >= 5000) begin
                adv = 1'b1;
                exp_done_q.push_back(m_bin);
                m_bin   = (m_bin + 1) % 4;
                m_start = e.ts;
                for (int k = 0; k < 512; k++) m_mem[m_bin * 512 + k] = 0;
            end
        end
        drop = (gx >= 16) || (gy >= 16);
        if (!drop) begin
            a = m_bin * 512 + gy * 32 + gx * 2 + e.pol;
            if (m_mem[a] < 255) m_mem[a]++;
        end
    endtask

    // Feeds queued events as a FIFO would and checks pulses, gaps and clear time.
    task automatic run_events(output int pops);
        int cyc, last_pop, settle, busy_n, done_n, drop_n, adv_n, drop_exp, exp_done;
        bit prev_normal, adv, drop;
        pops = 0; cyc = 0; last_pop = 0; settle = 0; busy_n = 0;
        done_n = 0; drop_n = 0; adv_n = 0; drop_exp = 0; prev_normal = 1'b0;
        while ((evq.size() > 0 || settle < 6) && cyc < 40000) begin
            @(negedge clk);
            if (evq.size() > 0) begin
                fifo_empty = 1'b0;
                ev_x   = 9'(evq[0].x);
                ev_y   = 9'(evq[0].y);
                ev_pol = 1'(evq[0].pol);
                ev_ts  = 16'(evq[0].ts);
            end else begin
                fifo_empty = 1'b1;
            end
            #1;
            check("pop_gated", 32'(fifo_pop & (busy | fifo_empty)), 0);
            if (busy) busy_n++;
            if (bin_done) begin
                done_n++;
                exp_done = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : -1;
                check("done_bin", 32'(done_bin), exp_done);
            end
            if (ev_dropped) drop_n++;
            if (fifo_pop) begin
                if (prev_normal) check("pop_gap", cyc - last_pop, 3);
                model_apply(evq.pop_front(), adv, drop);
                if (adv) adv_n++;
                if (drop) drop_exp++;
                prev_normal = !adv && !drop;
                last_pop = cyc;
                pops++;
                settle = 0;
            end else if (evq.size() == 0 && !busy) begin
                settle++;
            end else begin
                settle = 0;
            end
            cyc++;
        end
        fifo_empty = 1'b1;
        check("run_timeout", evq.size(), 0);
        check("bin_done_count", done_n, adv_n);
        check("clear_busy_cycles", busy_n, adv_n * 512);
        check("dropped_count", drop_n, drop_exp);
    endtask

    // Counts busy cycles from reset release; pop must stay low with a pending event.
    task automatic count_init(input string tag);
        int n;
        bit popped;
        n = 0; popped = 1'b0;
        #1;
        while (busy === 1'b1 && n < 5000) begin
            if (fifo_pop !== 1'b0) popped = 1'b1;
            n++;
            @(negedge clk);
            #1;
        end
        fifo_empty = 1'b1;
        check({tag, "_busy_cycles"}, n, 2048);
        check({tag, "_no_pop"}, 32'(popped), 0);
    endtask

    task automatic check_rd(input string tag, input int a, input int exp);
        rd_addr = 11'(a);
        @(negedge clk);
        check(tag, 32'(rd_data), exp);
    endtask

    task automatic check_dump(input string tag);
        rd_addr = '0;
        @(negedge clk);
        for (int i = 0; i < NE; i++) begin
            check($sformatf("%s[%0d]", tag, i), 32'(rd_data), m_mem[i]);
            rd_addr = 11'(i + 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int pops, drops, ts;
        rst = 1'b1; fifo_empty = 1'b1; ev_x = '0; ev_y = '0; ev_pol = 1'b0; ev_ts = '0;
        rd_addr = '0;
        fifo_empty2 = 1'b1; ev_x2 = '0; ev_y2 = '0; ev_pol2 = 1'b0; ev_ts2 = '0; rd_addr2 = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_fifo_pop", 32'(fifo_pop), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_cur_bin", 32'(cur_bin), 0);
        check("rst_bin_done", 32'(bin_done), 0);
        check("rst_done_bin", 32'(done_bin), 0);
        check("rst_ev_dropped", 32'(ev_dropped), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_busy_g3", 32'(busy2), 1);

        // INIT: 2048 busy cycles, no pop even with an event waiting
        fifo_empty = 1'b0; ev_x = 9'd100; ev_y = 9'd50; ev_pol = 1'b1; ev_ts = 16'd10;
        rst = 1'b0;
        count_init("init");
        check_dump("init_zero");

        // GRID_BITS=3 instance: out-of-grid event is popped and dropped
        @(negedge clk);
        fifo_empty2 = 1'b0; ev_x2 = 9'd300; ev_y2 = 9'd0; ev_pol2 = 1'b0; ev_ts2 = 16'd10;
        #1;
        check("g3_pop_drop_ev", 32'(fifo_pop2), 1);
        drops = 0;
        @(negedge clk);
        fifo_empty2 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ev_dropped2) drops++;
        end
        check("g3_drop_pulses", drops, 1);
        fifo_empty2 = 1'b0; ev_x2 = 9'd100; ev_y2 = 9'd40; ev_pol2 = 1'b1; ev_ts2 = 16'd20;
        #1;
        check("g3_pop_in_grid", 32'(fifo_pop2), 1);
        drops = 0;
        @(negedge clk);
        fifo_empty2 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ev_dropped2) drops++;
        end
        check("g3_in_grid_no_drop", drops, 0);
        rd_addr2 = '0;
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            check($sformatf("g3_mem[%0d]", i), 32'(rd_data2), (i == 23) ? 1 : 0);
            rd_addr2 = 9'(i + 1);
            @(negedge clk);
        end

        // Single event lands at {0,1,3,1}
        evq.push_back(mk(100, 50, 1, 10));
        run_events(pops);
        check("t2_pops", pops, 1);
        check_rd("t2_count", 39, 1);
        check("t2_cur_bin", 32'(cur_bin), 0);

        // Saturation at 255 with 3-cycle pop spacing
        for (int i = 0; i < 300; i++) evq.push_back(mk(100, 50, 0, 10));
        run_events(pops);
        check("t3_pops", pops, 300);
        check_rd("t3_saturate", 38, 255);

        // Bin advance after 5000 ticks
        evq.push_back(mk(100, 50, 0, 10));
        evq.push_back(mk(100, 50, 0, 5010));
        run_events(pops);
        check("t4_cur_bin", 32'(cur_bin), 1);
        check_rd("t4_bin1_count", 550, 1);

        // Timestamp wrap, then advances wrapping the ring and clearing stale bin 0
        evq.push_back(mk(0, 0, 1, 65000));
        evq.push_back(mk(0, 0, 1, 3000));
        evq.push_back(mk(0, 0, 1, 5000));
        evq.push_back(mk(0, 0, 1, 10100));
        run_events(pops);
        check("t5_cur_bin", 32'(cur_bin), 0);
        check_rd("t5_stale_38", 38, 0);
        check_rd("t5_stale_39", 39, 0);
        check_rd("t5_new_bin0", 1, 1);
        check_rd("t5_bin1_kept", 550, 1);
        check_dump("t5_mem");

        // Reset in the middle of a CLEAR
        @(negedge clk);
        fifo_empty = 1'b0; ev_x = 9'd10; ev_y = 9'd10; ev_pol = 1'b0; ev_ts = 16'd20000;
        #1;
        check("t6_pop", 32'(fifo_pop), 1);
        @(negedge clk);
        fifo_empty = 1'b1;
        repeat (100) @(negedge clk);
        check("t6_busy_in_clear", 32'(busy), 1);
        check("t6_cur_bin_adv", 32'(cur_bin), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("t6_rst_cur_bin", 32'(cur_bin), 0);
        count_init("t6_reinit");
        check_dump("t6_zero");

        // Random event burst
        ts = 20000;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 11) == 0) ts += int'($urandom_range(5000, 60000));
            else                            ts += int'($urandom_range(0, 1200));
            ts = ts % 65536;
            evq.push_back(mk(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                             int'($urandom_range(0, 1)), ts));
        end
        run_events(pops);
        check("rand_pops", pops, 120);
        check("rand_cur_bin", 32'(cur_bin), m_bin);
        check_dump("rand_mem");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
